// File: rtl/vector_scoreboard_mu.sv
// vector_scoreboard_mu: in-order vector dispatch scoreboard.
//   Tracks a pending bit (and producer kind) per vector register, including
//   mask v0. It also tracks NUM_ALU ALU pipes, each with a multicycle occupancy
//   timer, and a count of in-flight memory operations. One instruction is
//   dispatched per cycle.
//
// Configuration macro: SB_PERF_CNT_EN adds three saturating 32-bit counters:
//   perf_stall_raw, perf_stall_unit and perf_dispatch.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   issue_*                   : pre-decoded FIFO head (valid, dest, srcs, mask,
//                               class, vset)
//   pop_data                  : consume the FIFO head this cycle
//   dispatch_valid/ready      : handshake to the vector unit
//   dispatch_unit             : lowest free ALU pipe (don't-care for mem ops)
//   alu_done/alu_done_dest    : per-pipe writeback strobes and vregs
//   mem_done/mem_done_dest    : memory completion and its vreg
//   sb_busy                   : any reg pending or any mem op in flight

// One ALU pipe occupancy timer. A multicycle op loads MC_CYCLES-1, so the
// pipe reads free again exactly MC_CYCLES cycles after the push.
module vsb_alu_pipe #(
  parameter int MC_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_free
);
  localparam int TW = $clog2(MC_CYCLES);

  logic [TW-1:0] r_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_timer <= '0;
    else if (i_load)           r_timer <= TW'(MC_CYCLES - 1);
    else if (r_timer != '0)    r_timer <= r_timer - 1'b1;
  end

  assign o_free = (r_timer == '0);
endmodule

module vector_scoreboard_mu #(
  parameter  int REGISTER_NUMBERS = 32,
  parameter  int NUM_ALU          = 2,
  parameter  int MC_CYCLES        = 4,
  parameter  int MEM_OUTSTANDING  = 2,
  localparam int RW               = $clog2(REGISTER_NUMBERS),
  localparam int UW               = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [RW-1:0]         issue_dest,
  input  logic [RW-1:0]         issue_src_a,
  input  logic                  issue_use_a,
  input  logic [RW-1:0]         issue_src_b,
  input  logic                  issue_use_b,
  input  logic                  issue_masked,
  input  logic [1:0]            issue_class,
  input  logic                  issue_vset,
  output logic                  pop_data,
  output logic                  dispatch_valid,
  input  logic                  dispatch_ready,
  output logic [UW-1:0]         dispatch_unit,
  input  logic [NUM_ALU-1:0]    alu_done,
  input  logic [NUM_ALU*RW-1:0] alu_done_dest,
  input  logic                  mem_done,
  input  logic [RW-1:0]         mem_done_dest,
  output logic                  sb_busy
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_raw,
  output logic [31:0]           perf_stall_unit,
  output logic [31:0]           perf_dispatch
`endif
);
  localparam int CW = $clog2(MEM_OUTSTANDING + 1);

  typedef enum logic [1:0] {K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2} kind_e;

  logic [REGISTER_NUMBERS-1:0] r_pend;
  kind_e                       r_kind [REGISTER_NUMBERS];
  logic [CW-1:0]               r_mem_cnt;

  logic [REGISTER_NUMBERS-1:0] w_clr, w_avail, w_set;
  logic [NUM_ALU-1:0]          w_pipe_free, w_pipe_load;
  logic [UW-1:0]               w_unit_sel;
  logic                        w_is_mem, w_is_mc, w_unit_ok, w_opnd_ok, w_ready, w_push;
  logic                        w_mem_inc, w_mem_dec;

  // Completion decode. Several strobes hitting one reg simply OR into one clear.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_ALU; i++)
      if (alu_done[i]) w_clr[alu_done_dest[i*RW +: RW]] = 1'b1;
    if (mem_done) w_clr[mem_done_dest] = 1'b1;
  end

  // Same-cycle bypass: a reg completing this cycle is already usable.
  assign w_avail = ~r_pend | w_clr;

  for (genvar g = 0; g < NUM_ALU; g++) begin : g_pipe
    vsb_alu_pipe #(.MC_CYCLES(MC_CYCLES)) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_pipe_load[g]),
      .o_free (w_pipe_free[g])
    );
    assign w_pipe_load[g] = w_push & w_is_mc & (w_unit_sel == UW'(g));
  end

  // Lowest-index free pipe wins; scan downwards so the lowest overwrites last.
  always_comb begin
    w_unit_sel = '0;
    for (int i = NUM_ALU - 1; i >= 0; i--)
      if (w_pipe_free[i]) w_unit_sel = UW'(i);
  end

  assign w_is_mem  = issue_class[1];
  assign w_is_mc   = (issue_class == 2'b01);
  // A mem slot freed by a completion this cycle can be reused immediately.
  assign w_unit_ok = w_is_mem ? ((r_mem_cnt < CW'(MEM_OUTSTANDING)) | mem_done)
                              : (|w_pipe_free);
  assign w_opnd_ok = w_avail[issue_dest]
                   & (!issue_use_a  | w_avail[issue_src_a])
                   & (!issue_use_b  | w_avail[issue_src_b])
                   & (!issue_masked | w_avail[0]);
  assign w_ready   = !issue_vset & w_opnd_ok & w_unit_ok;

  assign dispatch_valid = issue_valid & w_ready;
  assign w_push         = dispatch_valid & dispatch_ready;
  assign pop_data       = w_push | (issue_valid & issue_vset);
  assign dispatch_unit  = w_unit_sel;

  assign w_set = w_push ? (REGISTER_NUMBERS'(1) << issue_dest) : '0;

  // Set after clear: a push to a reg completing in the same cycle stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REGISTER_NUMBERS; r++) r_kind[r] <= K_ALU;
    end else if (w_push) begin
      case (issue_class)
        2'b10:   r_kind[issue_dest] <= K_LOAD;
        2'b11:   r_kind[issue_dest] <= K_STORE;
        default: r_kind[issue_dest] <= K_ALU;
      endcase
    end
  end

  // Producer kind is kept for debug visibility only.
  logic w_unused_kind;
  always_comb begin
    w_unused_kind = 1'b0;
    for (int r = 0; r < REGISTER_NUMBERS; r++) w_unused_kind ^= ^r_kind[r];
  end

  // A completion with nothing in flight is ignored so the count never wraps.
  assign w_mem_inc = w_push & w_is_mem;
  assign w_mem_dec = mem_done & (r_mem_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_mem_cnt <= '0;
    else if (w_mem_inc & !w_mem_dec) r_mem_cnt <= r_mem_cnt + 1'b1;
    else if (w_mem_dec & !w_mem_inc) r_mem_cnt <= r_mem_cnt - 1'b1;
  end

  assign sb_busy = (|r_pend) | (r_mem_cnt != '0);

`ifdef SB_PERF_CNT_EN
  logic w_stall_raw, w_stall_unit;
  assign w_stall_raw  = issue_valid & !issue_vset & !w_opnd_ok;
  assign w_stall_unit = issue_valid & !issue_vset &  w_opnd_ok & !w_unit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_raw  <= '0;
      perf_stall_unit <= '0;
      perf_dispatch   <= '0;
    end else begin
      if (w_stall_raw  && perf_stall_raw  != '1) perf_stall_raw  <= perf_stall_raw  + 1'b1;
      if (w_stall_unit && perf_stall_unit != '1) perf_stall_unit <= perf_stall_unit + 1'b1;
      if (w_push       && perf_dispatch   != '1) perf_dispatch   <= perf_dispatch   + 1'b1;
    end
  end
`endif
endmodule
